seg7_scan_controller: RTL and testbench

//  Time-multiplexed scan sequencer for the 7-segment display chain.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decoder.sv | 41 ++++
 rtl/seg7_scan_controller.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared state encoding and glyph constants for the 7-segment scan path.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package seg7_pkg;

  localparam int SHIFT_WORD_W = 16;
  localparam int SEL_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG,
    ST_ACK,
    ST_DONE,
    ST_DWELL
  } scan_state_e;

  // Glyphs as {g,f,e,d,c,b,a}, bit set means segment lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Maps one BCD value plus blank and dp flags to an {dp,g,f,e,d,c,b,a} byte.
// Latency: purely combinational.
// Backpressure: none.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  // Look up the glyph; blanking hides the digit but leaves the dp untouched.
  always_comb begin
    glyph = SEG_BLANK;
    if (!blank) begin
      case (value)
        4'd0:    glyph = SEG_0;
        4'd1:    glyph = SEG_1;
        4'd2:    glyph = SEG_2;
        4'd3:    glyph = SEG_3;
        4'd4:    glyph = SEG_4;
        4'd5:    glyph = SEG_5;
        4'd6:    glyph = SEG_6;
        4'd7:    glyph = SEG_7;
        4'd8:    glyph = SEG_8;
        4'd9:    glyph = SEG_9;
        4'd10:   glyph = SEG_DASH;
        default: glyph = SEG_BLANK;
      endcase
    end
  end

  // Polarity is applied last so the dp bit is inverted along with the glyph.
  assign seg = SEG_ACTIVE_LOW ? ~{dp, glyph} : {dp, glyph};

endmodule

// File: rtl/seg7_scan_controller.sv
// Scans NUM_DIGITS BCD digits into a 595 chain, one {select, segments} word per step.
// Latency: trigger 2 cycles after leaving IDLE; each digit then waits for the transfer plus DWELL_CYCLES.
// Backpressure: waits indefinitely for shift_busy_i to rise then fall; LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    shift_busy_i,
  output logic                    shift_trig_o,
  output logic [SHIFT_WORD_W-1:0] shift_word_o,
  output logic                    frame_start_o
);

  localparam int               CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]       SEL_OFF    = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  scan_state_e             state_q, state_d;
  logic [2:0]              digit_idx_q;
  logic [CNT_W-1:0]        dwell_cnt_q;
  logic [4*NUM_DIGITS-1:0] snap_bcd_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0]   frame_dp;
  logic [3:0]              digit_val [SEL_W];
  logic [SEL_W-1:0]        digit_dp;
  logic [SEL_W-1:0]        digit_blank;
  logic [7:0]              seg_byte;
  logic [7:0]              sel_byte;
  logic                    dwell_done;
  logic                    last_digit;

  // Digit 0 sees live inputs (snapshot being taken this cycle); later digits see the frame snapshot.
  assign frame_bcd  = (digit_idx_q == 3'd0) ? bcd_i : snap_bcd_q;
  assign frame_dp   = (digit_idx_q == 3'd0) ? dp_i  : snap_dp_q;
  assign dwell_done = (dwell_cnt_q == '0);
  assign last_digit = (digit_idx_q == LAST_IDX);

  // Pad the frame out to eight slots so the 3-bit digit index always addresses a full array.
  for (genvar g = 0; g < SEL_W; g++) begin : g_unpack
    if (g < NUM_DIGITS) begin : g_live
      assign digit_val[g] = frame_bcd[4*g +: 4];
      assign digit_dp[g]  = frame_dp[g];
    end else begin : g_pad
      assign digit_val[g] = 4'd0;
      assign digit_dp[g]  = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_nz;

  // Zero digits above the most significant nonzero digit go dark; digit 0 is always shown.
  always_comb begin
    higher_nz   = 1'b0;
    digit_blank = '0;
    for (int i = SEL_W - 1; i >= 1; i--) begin
      digit_blank[i] = !higher_nz && (digit_val[i] == 4'd0);
      higher_nz      = higher_nz || (digit_val[i] != 4'd0);
    end
  end
`else
  assign digit_blank = '0;
`endif

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decoder (
    .value(digit_val[digit_idx_q]),
    .blank(digit_blank[digit_idx_q]),
    .dp   (digit_dp[digit_idx_q]),
    .seg  (seg_byte)
  );

  // Only the current digit is selected; indices never reach unused select bits, so those stay inactive.
  assign sel_byte = SEL_ACTIVE_LOW ? ~(8'd1 << digit_idx_q) : (8'd1 << digit_idx_q);

  // Scan state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: busy is only looked at in ACK and DONE, so early busy cannot skip a step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_TRIG;
      ST_TRIG:  state_d = ST_ACK;
      ST_ACK:   if (shift_busy_i) state_d = ST_DONE;
      ST_DONE:  if (!shift_busy_i) state_d = ST_DWELL;
      ST_DWELL: if (dwell_done) state_d = en_i ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pulses decoded straight from the state so each lasts exactly one cycle.
  always_comb begin
    shift_trig_o  = (state_q == ST_TRIG);
    frame_start_o = (state_q == ST_LOAD) && (digit_idx_q == 3'd0);
  end

  // Frame snapshot and output word, both captured in LOAD and held until the next LOAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      shift_word_o <= {SEL_OFF, SEG_OFF};
    end else if (state_q == ST_LOAD) begin
      if (digit_idx_q == 3'd0) begin
        snap_bcd_q <= bcd_i;
        snap_dp_q  <= dp_i;
      end
      shift_word_o <= {sel_byte, seg_byte};
    end
  end

  // Dwell countdown and digit advance; dropping en_i restarts the next scan from digit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_idx_q <= 3'd0;
      dwell_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_DONE: if (!shift_busy_i) dwell_cnt_q <= DWELL_LOAD;
        ST_DWELL: begin
          if (dwell_done) begin
            if (!en_i || last_digit) digit_idx_q <= 3'd0;
            else                     digit_idx_q <= digit_idx_q + 3'd1;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench: stimulus pushes reference words, a negedge monitor pops on every trigger.
// Shifter model raises busy the cycle after a trigger for BUSY_LEN cycles (optionally stalled).
// Reference decode is computed arithmetically from the frame value, not from RTL structure.
module tb_seg7_scan_controller;

  localparam int ND       = 4;
  localparam int DW       = 4;
  localparam int BUSY_LEN = 16;
  localparam int PERIOD   = 2 + 1 + BUSY_LEN + DW;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] bcd_i;
  logic [3:0]  dp_i;
  logic        shift_busy_i;
  logic        shift_trig_o;
  logic [15:0] shift_word_o;
  logic        frame_start_o;

  always #5 clk_i = ~clk_i;

  seg7_scan_controller #(
    .NUM_DIGITS    (ND),
    .DWELL_CYCLES  (DW),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .bcd_i        (bcd_i),
    .dp_i         (dp_i),
    .shift_busy_i (shift_busy_i),
    .shift_trig_o (shift_trig_o),
    .shift_word_o (shift_word_o),
    .frame_start_o(frame_start_o)
  );

  typedef struct packed {
    logic [15:0] word;
    logic        fs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   trig_count = 0;
  int   fs_count = 0;
  int   frames_pushed = 0;
  bit   chk_period = 1'b0;
  int   stall_cycles = 0;

  // Standard glyphs {g..a}: 0-9, dash for 10, blank for 11-15.
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected shifter word for digit idx of a frame whose value is bcd/dp (both active-low).
  function automatic logic [15:0] model_word(input logic [15:0] bcd, input logic [3:0] dp, input int idx);
    int         v;
    bit         blank;
    logic [7:0] seg;
    logic [7:0] sel;
    v     = int'((bcd >> (4 * idx)) & 16'hF);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx > 0) && ((bcd >> (4 * idx)) == 16'h0);
`endif
    seg = {dp[idx], blank ? 7'h00 : glyphs[v]};
    sel = 8'(1 << idx);
    return {~sel, ~seg};
  endfunction

  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp, input int ndig);
    exp_t e;
    for (int i = 0; i < ndig; i++) begin
      e.word = model_word(bcd, dp, i);
      e.fs   = (i == 0);
      sb.push_back(e);
    end
    frames_pushed++;
  endtask

  task automatic wait_trigs(input int target, input string name);
    int k = 0;
    while (trig_count < target && k < 1000) begin
      @(negedge clk_i);
      k++;
    end
    check(name, 32'(trig_count >= target), 32'd1);
  endtask

  // Raise en_i from IDLE and count cycles until the first trigger.
  task automatic start_and_measure(input string name);
    int k = 0;
    @(negedge clk_i);
    en_i = 1'b1;
    do begin
      @(negedge clk_i);
      k++;
    end while (!shift_trig_o && k < 50);
    check(name, k, 32'd2);
  endtask

  // Shifter model: busy rises one cycle after the trigger (plus optional stall).
  initial begin : shifter
    int st;
    shift_busy_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (shift_trig_o && rst_ni) begin
        st = stall_cycles;
        @(negedge clk_i);
        repeat (st) @(negedge clk_i);
        shift_busy_i = 1'b1;
        repeat (BUSY_LEN) @(negedge clk_i);
        shift_busy_i = 1'b0;
      end
    end
  end

  // Monitor: every trigger pops one expected word and checks word, frame_start and spacing.
  initial begin : monitor
    int   cyc;
    int   last;
    bit   last_valid;
    bit   fs_prev;
    exp_t e;
    cyc = 0; last = 0; last_valid = 1'b0; fs_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (shift_trig_o) begin
        trig_count++;
        check("trig_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("word", shift_word_o, e.word);
          check("frame_start", fs_prev, e.fs);
        end
        if (chk_period && last_valid) check("trig_period", cyc - last, PERIOD);
        last       = cyc;
        last_valid = 1'b1;
      end
      if (frame_start_o) fs_count++;
      fs_prev = frame_start_o;
    end
  end

  initial begin : stim
    logic [15:0] b;
    logic [3:0]  d;
    int          tc;
    rst_ni = 1'b0; en_i = 1'b0; bcd_i = '0; dp_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_word", shift_word_o, 16'hFFFF);
    check("rst_trig", shift_trig_o, 1'b0);
    check("rst_frame_start", frame_start_o, 1'b0);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("idle_no_trig", trig_count, 0);

    // First frame 1234 / dp on digit 2; inputs swapped to 5678 after digit 0 loads.
    bcd_i = 16'h1234; dp_i = 4'b0100;
    push_frame(16'h1234, 4'b0100, ND);
    start_and_measure("start_latency");
    bcd_i = 16'h5678;
    chk_period = 1'b1;
    wait_trigs(4, "frame1_done");
    push_frame(16'h5678, 4'b0100, ND);
    wait_trigs(8, "frame2_done");
    tc = 8;

    // Directed leading-zero patterns, then random frames, each scrambled mid-frame.
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       b = 16'h0005;
        1:       b = 16'h0000;
        2:       b = 16'hABCF;
        default: b = 16'($urandom);
      endcase
      d = (i < 2) ? 4'h0 : 4'($urandom);
      bcd_i = b; dp_i = d;
      push_frame(b, d, ND);
      wait_trigs(tc + 1, "rand_first");
      bcd_i = 16'($urandom); dp_i = 4'($urandom);
      wait_trigs(tc + 4, "rand_done");
      tc += 4;
    end

    // Shifter never answers for 100 cycles: controller must sit in ACK.
    chk_period = 1'b0;
    stall_cycles = 100;
    b = 16'($urandom); d = 4'($urandom);
    bcd_i = b; dp_i = d;
    push_frame(b, d, ND);
    wait_trigs(tc + 1, "stall_trig");
    @(negedge clk_i);
    stall_cycles = 0;
    repeat (90) @(negedge clk_i);
    check("stall_no_retrig", trig_count, tc + 1);
    wait_trigs(tc + 2, "stall_recover");
    chk_period = 1'b1;
    wait_trigs(tc + 4, "stall_done");
    tc += 4;

    // Drop en_i during digit 1's transfer: nothing after it, restart at digit 0.
    chk_period = 1'b0;
    b = 16'($urandom); d = 4'($urandom);
    bcd_i = b; dp_i = d;
    push_frame(b, d, 2);
    wait_trigs(tc + 2, "en_drop_digit1");
    en_i = 1'b0;
    repeat (150) @(negedge clk_i);
    check("en_drop_no_trig", trig_count, tc + 2);
    check("en_drop_queue", sb.size(), 0);
    tc += 2;
    b = 16'($urandom); d = 4'($urandom);
    bcd_i = b; dp_i = d;
    push_frame(b, d, ND);
    start_and_measure("restart_latency");
    wait_trigs(tc + 1, "restart_first");
    chk_period = 1'b1;
    wait_trigs(tc + 4, "restart_done");
    tc += 4;

    // Reset in the middle of digit 0's dwell.
    chk_period = 1'b0;
    b = 16'($urandom); d = 4'($urandom);
    bcd_i = b; dp_i = d;
    push_frame(b, d, ND);
    wait_trigs(tc + 1, "pre_rst_trig");
    repeat (19) @(negedge clk_i);
    rst_ni = 1'b0; en_i = 1'b0;
    #1;
    check("mid_rst_word", shift_word_o, 16'hFFFF);
    check("mid_rst_trig", shift_trig_o, 1'b0);
    check("mid_rst_frame_start", frame_start_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.delete();
    repeat (20) @(negedge clk_i);
    check("post_rst_idle", trig_count, tc + 1);
    tc += 1;
    b = 16'($urandom); d = 4'($urandom);
    bcd_i = b; dp_i = d;
    push_frame(b, d, ND);
    start_and_measure("post_rst_latency");
    wait_trigs(tc + 4, "post_rst_done");
    tc += 4;

    repeat (5) @(negedge clk_i);
    check("queue_drained", sb.size(), 0);
    check("frame_start_count", fs_count, frames_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
